// File: rtl/ahb_pkg.sv
// Shared definitions for the AHB memory-subsystem arbiter slice.
package ahb_pkg;

   // Arbiter ownership states, one-hot encoded so each grant is a single flop bit.
   typedef enum logic [2:0] {
      IDLE     = 3'b001,
      GRANT_M0 = 3'b010,
      GRANT_M1 = 3'b100
   } arb_state_e;

   localparam logic HTRANS_IDLE   = 1'b0;
   localparam logic HTRANS_ACTIVE = 1'b1;

endpackage : ahb_pkg

// File: rtl/ahb_bus_mux.sv
// Combinational 2:1 steering of the address phase (by grant owner) and the
// write-data phase (by data-phase owner) from two masters onto the slave side.
module ahb_bus_mux
   import ahb_pkg::*;
#(
   parameter int ADDR_W = 31,
   parameter int DATA_W = 32
) (
   input  logic              addr_en,
   input  logic              addr_sel,
   input  logic              data_sel,
   input  logic [ADDR_W-1:0] HADDR0,
   input  logic [ADDR_W-1:0] HADDR1,
   input  logic              HWRITE0,
   input  logic              HWRITE1,
   input  logic              HTRANS0,
   input  logic              HTRANS1,
   input  logic              HBURST0,
   input  logic              HBURST1,
   input  logic [DATA_W-1:0] HWDATA0,
   input  logic [DATA_W-1:0] HWDATA1,
   output logic [ADDR_W-1:0] HADDR,
   output logic              HWRITE,
   output logic              HTRANS,
   output logic              HBURST,
   output logic [DATA_W-1:0] HWDATA
);

   // Address-phase select; with no owner the slave sees a quiet idle bus.
   always_comb begin
      HADDR  = '0;
      HWRITE = 1'b0;
      HTRANS = HTRANS_IDLE;
      HBURST = 1'b0;
      if (!addr_en) begin
         HADDR  = '0;
         HWRITE = 1'b0;
         HTRANS = HTRANS_IDLE;
         HBURST = 1'b0;
      end else if (addr_sel) begin
         HADDR  = HADDR1;
         HWRITE = HWRITE1;
         HTRANS = HTRANS1;
         HBURST = HBURST1;
      end else begin
         HADDR  = HADDR0;
         HWRITE = HWRITE0;
         HTRANS = HTRANS0;
         HBURST = HBURST0;
      end
   end

   // Write-data select follows the owner of the data phase, which lags the grant.
   always_comb begin
      HWDATA = HWDATA0;
      if (data_sel) begin
         HWDATA = HWDATA1;
      end else begin
         HWDATA = HWDATA0;
      end
   end

endmodule : ahb_bus_mux

// File: rtl/ahb_arbiter.sv
// Two-master round-robin AHB arbiter with forced release after MAX_BEATS
// consecutive active beats when the other master is waiting.
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int ADDR_W    = 31,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 16
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HBUSREQ0,
   input  logic              HBUSREQ1,
   input  logic [ADDR_W-1:0] HADDR0,
   input  logic [ADDR_W-1:0] HADDR1,
   input  logic              HWRITE0,
   input  logic              HWRITE1,
   input  logic              HTRANS0,
   input  logic              HTRANS1,
   input  logic              HBURST0,
   input  logic              HBURST1,
   input  logic [DATA_W-1:0] HWDATA0,
   input  logic [DATA_W-1:0] HWDATA1,
   output logic              HGRANT0,
   output logic              HGRANT1,
   output logic              HMASTER,
   output logic [ADDR_W-1:0] HADDR,
   output logic              HWRITE,
   output logic              HTRANS,
   output logic              HBURST,
   output logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY_IN,
   input  logic [DATA_W-1:0] HRDATA_IN,
   output logic              HREADY,
   output logic [DATA_W-1:0] HRDATA
);

   localparam int CNT_W = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BEATS - 1);

   arb_state_e       state_r;
   arb_state_e       state_s;
   logic             rr_last_r;
   logic             rr_last_s;
   logic [CNT_W-1:0] beat_cnt_r;
   logic [CNT_W-1:0] beat_cnt_s;
   logic             data_owner_r;
   logic             beat_last_s;

   assign beat_last_s = (beat_cnt_r == BEAT_LAST);

   // Grants and owner index decode straight from the one-hot state flops.
   assign HGRANT0 = (state_r == GRANT_M0);
   assign HGRANT1 = (state_r == GRANT_M1);
   assign HMASTER = (state_r == GRANT_M1);

   // Slave responses are shared by both masters.
   assign HREADY = HREADY_IN;
   assign HRDATA = HRDATA_IN;

   ahb_bus_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_bus_mux (
      .addr_en  (state_r != IDLE),
      .addr_sel (HMASTER),
      .data_sel (data_owner_r),
      .HADDR0   (HADDR0),
      .HADDR1   (HADDR1),
      .HWRITE0  (HWRITE0),
      .HWRITE1  (HWRITE1),
      .HTRANS0  (HTRANS0),
      .HTRANS1  (HTRANS1),
      .HBURST0  (HBURST0),
      .HBURST1  (HBURST1),
      .HWDATA0  (HWDATA0),
      .HWDATA1  (HWDATA1),
      .HADDR    (HADDR),
      .HWRITE   (HWRITE),
      .HTRANS   (HTRANS),
      .HBURST   (HBURST),
      .HWDATA   (HWDATA)
   );

   // Next ownership: round-robin on ties, release only at burst end or beat limit.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (HBUSREQ0 && HBUSREQ1) begin
               state_s = rr_last_r ? GRANT_M0 : GRANT_M1;
            end else if (HBUSREQ0) begin
               state_s = GRANT_M0;
            end else if (HBUSREQ1) begin
               state_s = GRANT_M1;
            end else begin
               state_s = IDLE;
            end
         end
         GRANT_M0: begin
            if ((!HBURST0 || beat_last_s) && HBUSREQ1) begin
               state_s = GRANT_M1;
            end else if (!HBUSREQ0 && !HBUSREQ1) begin
               state_s = IDLE;
            end else begin
               state_s = GRANT_M0;
            end
         end
         GRANT_M1: begin
            if ((!HBURST1 || beat_last_s) && HBUSREQ0) begin
               state_s = GRANT_M0;
            end else if (!HBUSREQ1 && !HBUSREQ0) begin
               state_s = IDLE;
            end else begin
               state_s = GRANT_M1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Pointer and beat counter follow the chosen next state.
   always_comb begin
      rr_last_s  = rr_last_r;
      beat_cnt_s = beat_cnt_r;
      if (state_s == GRANT_M0) begin
         rr_last_s = 1'b0;
      end else if (state_s == GRANT_M1) begin
         rr_last_s = 1'b1;
      end else begin
         rr_last_s = rr_last_r;
      end
      if (state_s != state_r) begin
         beat_cnt_s = '0;
      end else if ((HTRANS == HTRANS_ACTIVE) && !beat_last_s) begin
         beat_cnt_s = beat_cnt_r + CNT_W'(1);
      end else begin
         beat_cnt_s = beat_cnt_r;
      end
   end

   // Arbitration state advances only when the slave completes a transfer.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r      <= IDLE;
         rr_last_r    <= 1'b1;
         beat_cnt_r   <= '0;
         data_owner_r <= 1'b0;
      end else if (HREADY_IN) begin
         state_r      <= state_s;
         rr_last_r    <= rr_last_s;
         beat_cnt_r   <= beat_cnt_s;
         data_owner_r <= HMASTER;
      end else begin
         state_r      <= state_r;
         rr_last_r    <= rr_last_r;
         beat_cnt_r   <= beat_cnt_r;
         data_owner_r <= data_owner_r;
      end
   end

endmodule : ahb_arbiter

// File: tb/tb_ahb_arbiter.sv
// Directed testbench for ahb_arbiter with hand-computed expectations.
module tb_ahb_arbiter;

   localparam int ADDR_W = 31;
   localparam int DATA_W = 32;

   logic              HCLK;
   logic              HRESETn;
   logic              HBUSREQ0, HBUSREQ1;
   logic [ADDR_W-1:0] HADDR0, HADDR1;
   logic              HWRITE0, HWRITE1;
   logic              HTRANS0, HTRANS1;
   logic              HBURST0, HBURST1;
   logic [DATA_W-1:0] HWDATA0, HWDATA1;
   logic              HGRANT0, HGRANT1, HMASTER;
   logic [ADDR_W-1:0] HADDR;
   logic              HWRITE, HTRANS, HBURST;
   logic [DATA_W-1:0] HWDATA;
   logic              HREADY_IN;
   logic [DATA_W-1:0] HRDATA_IN;
   logic              HREADY;
   logic [DATA_W-1:0] HRDATA;

   int n_cmp;
   int n_err;
   int beats;

   ahb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(16)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HBUSREQ0  (HBUSREQ0),
      .HBUSREQ1  (HBUSREQ1),
      .HADDR0    (HADDR0),
      .HADDR1    (HADDR1),
      .HWRITE0   (HWRITE0),
      .HWRITE1   (HWRITE1),
      .HTRANS0   (HTRANS0),
      .HTRANS1   (HTRANS1),
      .HBURST0   (HBURST0),
      .HBURST1   (HBURST1),
      .HWDATA0   (HWDATA0),
      .HWDATA1   (HWDATA1),
      .HGRANT0   (HGRANT0),
      .HGRANT1   (HGRANT1),
      .HMASTER   (HMASTER),
      .HADDR     (HADDR),
      .HWRITE    (HWRITE),
      .HTRANS    (HTRANS),
      .HBURST    (HBURST),
      .HWDATA    (HWDATA),
      .HREADY_IN (HREADY_IN),
      .HRDATA_IN (HRDATA_IN),
      .HREADY    (HREADY),
      .HRDATA    (HRDATA)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle 2 time units past the rising edge.
   task automatic tick();
      @(posedge HCLK);
      #2;
   endtask

   task automatic idle_inputs();
      HBUSREQ0 = 1'b0; HBUSREQ1 = 1'b0;
      HADDR0 = '0; HADDR1 = '0;
      HWRITE0 = 1'b0; HWRITE1 = 1'b0;
      HTRANS0 = 1'b0; HTRANS1 = 1'b0;
      HBURST0 = 1'b0; HBURST1 = 1'b0;
      HWDATA0 = 32'h1111_1111; HWDATA1 = 32'h2222_2222;
      HREADY_IN = 1'b1;
      HRDATA_IN = 32'h0;
   endtask

   // Pulse reset away from the clock edge.
   task automatic do_reset();
      idle_inputs();
      HRESETn = 1'b0;
      #3;
      HRESETn = 1'b1;
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      idle_inputs();
      HRESETn = 1'b0;
      tick();

      // Reset state
      check_eq("rst_grant0", HGRANT0, 1'b0);
      check_eq("rst_grant1", HGRANT1, 1'b0);
      check_eq("rst_hmaster", HMASTER, 1'b0);
      check_eq("rst_htrans", HTRANS, 1'b0);
      check_eq("rst_hwdata", HWDATA, 32'h1111_1111);
      HRESETn = 1'b1;
      #1;

      // Single requester M0
      HBUSREQ0 = 1'b1;
      HADDR0   = 31'h100;
      tick();
      HTRANS0   = 1'b1;
      HRDATA_IN = 32'hCAFE_F00D;
      #1;
      check_eq("m0_grant0", HGRANT0, 1'b1);
      check_eq("m0_grant1", HGRANT1, 1'b0);
      check_eq("m0_hmaster", HMASTER, 1'b0);
      check_eq("m0_haddr", HADDR, 31'h100);
      check_eq("m0_htrans", HTRANS, 1'b1);
      check_eq("hrdata_bcast", HRDATA, 32'hCAFE_F00D);
      check_eq("hready_bcast", HREADY, 1'b1);
      HBUSREQ0 = 1'b0;
      HTRANS0  = 1'b0;
      tick();
      check_eq("idle_grant0", HGRANT0, 1'b0);
      check_eq("idle_haddr", HADDR, 31'h0);

      // Both request from reset, single transfers alternate 0,1,0,1,0
      do_reset();
      HBUSREQ0 = 1'b1; HBUSREQ1 = 1'b1;
      HTRANS0 = 1'b1; HTRANS1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq($sformatf("rr_grant0_%0d", i), HGRANT0, (i % 2 == 0) ? 1'b1 : 1'b0);
         check_eq($sformatf("rr_grant1_%0d", i), HGRANT1, (i % 2 == 1) ? 1'b1 : 1'b0);
         check_eq($sformatf("rr_hmaster_%0d", i), HMASTER, (i % 2 == 1) ? 1'b1 : 1'b0);
      end

      // Forced release after 16 beats of M0 burst with M1 waiting
      do_reset();
      HBUSREQ0 = 1'b1; HBUSREQ1 = 1'b1;
      HTRANS0 = 1'b1; HBURST0 = 1'b1;
      HTRANS1 = 1'b1; HBURST1 = 1'b0;
      beats = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (HGRANT1) break;
         if (HGRANT0 && HTRANS) beats++;
      end
      check_eq("burst_beats", beats, 16);
      check_eq("burst_handover", HGRANT1, 1'b1);

      // HREADY_IN low for 3 cycles freezes handover back to M0
      HREADY_IN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("wait_grant1_%0d", i), HGRANT1, 1'b1);
         check_eq($sformatf("wait_hmaster_%0d", i), HMASTER, 1'b1);
         check_eq($sformatf("wait_hwdata_%0d", i), HWDATA, 32'h1111_1111);
      end
      HREADY_IN = 1'b1;
      tick();
      check_eq("resume_grant0", HGRANT0, 1'b1);
      check_eq("resume_hwdata", HWDATA, 32'h2222_2222);

      // M1 write to address 5 just before handover to M0
      do_reset();
      HBUSREQ1 = 1'b1; HADDR1 = 31'h5; HWRITE1 = 1'b1;
      HTRANS1 = 1'b1; HBURST1 = 1'b0;
      tick();
      check_eq("wr_hmaster", HMASTER, 1'b1);
      check_eq("wr_haddr", HADDR, 31'h5);
      check_eq("wr_hwrite", HWRITE, 1'b1);
      HBUSREQ0 = 1'b1;
      HTRANS0  = 1'b1;
      tick();
      HWDATA1 = 32'hDEAD_BEEF;
      HWDATA0 = 32'h0BAD_0BAD;
      #1;
      check_eq("wr_dp_hmaster", HMASTER, 1'b0);
      check_eq("wr_dp_grant0", HGRANT0, 1'b1);
      check_eq("wr_dp_hwdata", HWDATA, 32'hDEAD_BEEF);
      tick();
      check_eq("wr_next_hwdata", HWDATA, 32'h0BAD_0BAD);

      // Asynchronous reset mid-burst
      do_reset();
      HBUSREQ0 = 1'b1; HTRANS0 = 1'b1; HBURST0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
      end
      check_eq("pre_rst_grant0", HGRANT0, 1'b1);
      HRESETn = 1'b0;
      #1;
      check_eq("async_grant0", HGRANT0, 1'b0);
      check_eq("async_grant1", HGRANT1, 1'b0);
      check_eq("async_htrans", HTRANS, 1'b0);
      HRESETn = 1'b1;
      tick();
      check_eq("post_rst_grant0", HGRANT0, 1'b1);
      check_eq("post_rst_htrans", HTRANS, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_ahb_arbiter
